// File: rtl/axis_dw_cvt_downsizer.sv
// AXI-Stream width downsizer: one wide slave word becomes SCALE narrow master
// beats, lowest slice first, with per-byte keep and user kept aligned to the data.
// An optional filter skips narrow slices whose keep is all zero.
module axis_dw_cvt_downsizer #(
    parameter int    slave_data_width              = 32,
    parameter int    slave_user_width_foreach_byte = 1,
    parameter int    master_data_width             = 16,
    parameter string en_keep_all0_filter           = "false",
    // Only meaningful for behavioural models; this RTL updates on the clock edge.
    parameter int    simulation_delay              = 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [slave_data_width-1:0]                        s_axis_data,
    input  logic [slave_data_width/8-1:0]                      s_axis_keep,
    input  logic [slave_user_width_foreach_byte*slave_data_width/8-1:0]  s_axis_user,
    input  logic                                               s_axis_last,
    input  logic                                               s_axis_valid,
    output logic                                               s_axis_ready,
    output logic [master_data_width-1:0]                       m_axis_data,
    output logic [master_data_width/8-1:0]                     m_axis_keep,
    output logic [slave_user_width_foreach_byte*master_data_width/8-1:0] m_axis_user,
    output logic                                               m_axis_last,
    output logic                                               m_axis_valid,
    input  logic                                               m_axis_ready
);

    localparam int SCALE = slave_data_width / master_data_width;
    localparam int SB    = slave_data_width / 8;
    localparam int MB    = master_data_width / 8;
    localparam int U     = slave_user_width_foreach_byte;
    localparam int UM    = U * MB;
    localparam int IDX_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam bit FILT  = (en_keep_all0_filter == "true");

    // Holding register and beat state
    logic [slave_data_width-1:0] r_data;
    logic [SB-1:0]               r_keep;
    logic [U*SB-1:0]             r_user;
    logic                        r_last;
    logic                        r_hold_vld;
    logic [IDX_W-1:0]            r_idx;

    // Per-slice views of the held word, and slice-level keep summaries
    logic [master_data_width-1:0] w_dslice [SCALE];
    logic [MB-1:0]                w_kslice [SCALE];
    logic [UM-1:0]                w_uslice [SCALE];
    logic [SCALE-1:0]             w_held_nz;   // held slice has any keep bit
    logic [SCALE-1:0]             w_in_nz;     // incoming slice has any keep bit
    logic [SCALE-1:0]             w_above;     // held nonzero slices beyond idx

    logic [IDX_W-1:0] w_next_idx;
    logic [IDX_W-1:0] w_first_idx;
    logic             w_final;
    logic             w_m_hs;
    logic             w_s_hs;
    logic             w_load;

    genvar gi;
    generate
        for (gi = 0; gi < SCALE; gi++) begin : g_slice
            assign w_dslice[gi]  = r_data[gi*master_data_width +: master_data_width];
            assign w_kslice[gi]  = r_keep[gi*MB +: MB];
            assign w_uslice[gi]  = r_user[gi*UM +: UM];
            assign w_held_nz[gi] = |r_keep[gi*MB +: MB];
            assign w_in_nz[gi]   = |s_axis_keep[gi*MB +: MB];
            assign w_above[gi]   = w_held_nz[gi] & (r_idx < IDX_W'(gi));
        end
    endgenerate

    // Priority search for the lowest useful slice: next one above idx in the
    // held word, and the first one in the incoming word.
    always_comb begin
        w_next_idx  = '0;
        w_first_idx = '0;
        for (int k = SCALE - 1; k >= 0; k--) begin
            if (w_above[k]) w_next_idx  = IDX_W'(k);
            if (w_in_nz[k]) w_first_idx = IDX_W'(k);
        end
    end

    // With the filter, the beat is final once no later slice carries keep.
    assign w_final = FILT ? ~|w_above : (r_idx == IDX_W'(SCALE - 1));

    assign m_axis_valid = r_hold_vld;
    assign m_axis_data  = w_dslice[r_idx];
    assign m_axis_keep  = w_kslice[r_idx];
    assign m_axis_user  = w_uslice[r_idx];
    assign m_axis_last  = r_last & w_final;

    assign s_axis_ready = ~rst & (~r_hold_vld | (m_axis_ready & w_final));

    assign w_m_hs = r_hold_vld & m_axis_ready;
    assign w_s_hs = s_axis_valid & s_axis_ready;
    // An all-zero-keep word that does not close a packet carries nothing and
    // is swallowed; one with last is kept so the packet boundary survives.
    assign w_load = w_s_hs & ~(FILT & ~|w_in_nz & ~s_axis_last);

    // Load a new word, advance through slices, or go idle after the final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_keep     <= '0;
            r_user     <= '0;
            r_last     <= 1'b0;
            r_hold_vld <= 1'b0;
            r_idx      <= '0;
        end else if (w_load) begin
            r_data     <= s_axis_data;
            r_keep     <= s_axis_keep;
            r_user     <= s_axis_user;
            r_last     <= s_axis_last;
            r_hold_vld <= 1'b1;
            r_idx      <= FILT ? w_first_idx : '0;
        end else if (w_m_hs) begin
            if (w_final) begin
                r_hold_vld <= 1'b0;
            end else begin
                r_idx <= FILT ? w_next_idx : r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_dw_cvt_downsizer.sv
// Directed bench: dut_a is 32->16 without the filter, dut_b is 64->16 with the
// zero-keep filter enabled.
module tb_axis_dw_cvt_downsizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // dut_a: 32 -> 16, filter off
    logic        a_rst;
    logic [31:0] a_s_data;
    logic [3:0]  a_s_keep;
    logic [3:0]  a_s_user;
    logic        a_s_last, a_s_valid, a_s_ready;
    logic [15:0] a_m_data;
    logic [1:0]  a_m_keep;
    logic [1:0]  a_m_user;
    logic        a_m_last, a_m_valid, a_m_ready;

    // dut_b: 64 -> 16, filter on
    logic        b_rst;
    logic [63:0] b_s_data;
    logic [7:0]  b_s_keep;
    logic [7:0]  b_s_user;
    logic        b_s_last, b_s_valid, b_s_ready;
    logic [15:0] b_m_data;
    logic [1:0]  b_m_keep;
    logic [1:0]  b_m_user;
    logic        b_m_last, b_m_valid, b_m_ready;

    axis_dw_cvt_downsizer #(
        .slave_data_width(32), .slave_user_width_foreach_byte(1),
        .master_data_width(16), .en_keep_all0_filter("false"), .simulation_delay(1)
    ) dut_a (
        .clk(clk), .rst(a_rst),
        .s_axis_data(a_s_data), .s_axis_keep(a_s_keep), .s_axis_user(a_s_user),
        .s_axis_last(a_s_last), .s_axis_valid(a_s_valid), .s_axis_ready(a_s_ready),
        .m_axis_data(a_m_data), .m_axis_keep(a_m_keep), .m_axis_user(a_m_user),
        .m_axis_last(a_m_last), .m_axis_valid(a_m_valid), .m_axis_ready(a_m_ready)
    );

    axis_dw_cvt_downsizer #(
        .slave_data_width(64), .slave_user_width_foreach_byte(1),
        .master_data_width(16), .en_keep_all0_filter("true"), .simulation_delay(1)
    ) dut_b (
        .clk(clk), .rst(b_rst),
        .s_axis_data(b_s_data), .s_axis_keep(b_s_keep), .s_axis_user(b_s_user),
        .s_axis_last(b_s_last), .s_axis_valid(b_s_valid), .s_axis_ready(b_s_ready),
        .m_axis_data(b_m_data), .m_axis_keep(b_m_keep), .m_axis_user(b_m_user),
        .m_axis_last(b_m_last), .m_axis_valid(b_m_valid), .m_axis_ready(b_m_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected beats for the back-to-back run
    logic [31:0] bb_word [4];
    logic        bb_wlast [4];
    logic [15:0] bb_beat [8];
    logic        bb_blast [8];

    initial begin
        bb_word[0] = 32'h0102_0304; bb_wlast[0] = 1'b0;
        bb_word[1] = 32'h1112_1314; bb_wlast[1] = 1'b1;
        bb_word[2] = 32'h2122_2324; bb_wlast[2] = 1'b0;
        bb_word[3] = 32'h3132_3334; bb_wlast[3] = 1'b1;
        bb_beat[0] = 16'h0304; bb_blast[0] = 1'b0;
        bb_beat[1] = 16'h0102; bb_blast[1] = 1'b0;
        bb_beat[2] = 16'h1314; bb_blast[2] = 1'b0;
        bb_beat[3] = 16'h1112; bb_blast[3] = 1'b1;
        bb_beat[4] = 16'h2324; bb_blast[4] = 1'b0;
        bb_beat[5] = 16'h2122; bb_blast[5] = 1'b0;
        bb_beat[6] = 16'h3334; bb_blast[6] = 1'b0;
        bb_beat[7] = 16'h3132; bb_blast[7] = 1'b1;

        a_rst = 1'b1; a_s_data = '0; a_s_keep = '0; a_s_user = '0;
        a_s_last = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b1;
        b_rst = 1'b1; b_s_data = '0; b_s_keep = '0; b_s_user = '0;
        b_s_last = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b1;

        // ---------------- reset state ----------------
        tick; tick;
        check("rst_valid", a_m_valid, 1'b0);
        check("rst_data",  a_m_data,  16'h0);
        check("rst_keep",  a_m_keep,  2'h0);
        check("rst_user",  a_m_user,  2'h0);
        check("rst_last",  a_m_last,  1'b0);
        check("rst_sready_in_rst", a_s_ready, 1'b0);
        check("rst_b_valid", b_m_valid, 1'b0);
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        check("rst_sready_after", a_s_ready, 1'b1);
        check("rst_b_sready_after", b_s_ready, 1'b1);

        // ---------------- basic split, filter off ----------------
        a_s_data = 32'hDDCC_BBAA; a_s_keep = 4'hF; a_s_user = 4'hA;
        a_s_last = 1'b1; a_s_valid = 1'b1;
        tick;
        a_s_valid = 1'b0;
        #1;
        check("basic_b1_valid", a_m_valid, 1'b1);
        check("basic_b1_data",  a_m_data,  16'hBBAA);
        check("basic_b1_keep",  a_m_keep,  2'h3);
        check("basic_b1_user",  a_m_user,  2'h2);
        check("basic_b1_last",  a_m_last,  1'b0);
        check("basic_b1_sready", a_s_ready, 1'b0);
        tick;
        check("basic_b2_valid", a_m_valid, 1'b1);
        check("basic_b2_data",  a_m_data,  16'hDDCC);
        check("basic_b2_keep",  a_m_keep,  2'h3);
        check("basic_b2_user",  a_m_user,  2'h2);
        check("basic_b2_last",  a_m_last,  1'b1);
        check("basic_b2_sready", a_s_ready, 1'b1);
        tick;
        check("basic_idle_valid", a_m_valid, 1'b0);

        // ---------------- back-to-back, 4 words ----------------
        begin
            int wi = 0;
            int bi = 0;
            bit started = 1'b0;
            for (int cyc = 0; cyc < 30 && bi < 8; cyc++) begin
                a_s_valid = (wi < 4);
                a_s_data  = (wi < 4) ? bb_word[wi] : 32'h0;
                a_s_last  = (wi < 4) ? bb_wlast[wi] : 1'b0;
                a_s_keep  = 4'hF;
                a_s_user  = 4'h0;
                #1;
                if (a_m_valid) begin
                    started = 1'b1;
                    check("b2b_data", a_m_data, bb_beat[bi]);
                    check("b2b_last", a_m_last, bb_blast[bi]);
                    bi++;
                end else if (started) begin
                    check("b2b_nogap_valid", a_m_valid, 1'b1);
                end
                if (a_s_valid && a_s_ready) wi++;
                tick;
            end
            check("b2b_beat_count", bi, 8);
            a_s_valid = 1'b0;
            #1;
            check("b2b_drained", a_m_valid, 1'b0);
        end

        // ---------------- backpressure ----------------
        a_s_data = 32'hDDCC_BBAA; a_s_keep = 4'hF; a_s_user = 4'h0;
        a_s_last = 1'b1; a_s_valid = 1'b1; a_m_ready = 1'b1;
        tick;
        a_s_valid = 1'b0; a_m_ready = 1'b0;
        #1;
        check("bp_stall1_data",   a_m_data,  16'hBBAA);
        check("bp_stall1_sready", a_s_ready, 1'b0);
        tick;
        check("bp_stall2_data",   a_m_data,  16'hBBAA);
        check("bp_stall2_keep",   a_m_keep,  2'h3);
        check("bp_stall2_last",   a_m_last,  1'b0);
        check("bp_stall2_valid",  a_m_valid, 1'b1);
        check("bp_stall2_sready", a_s_ready, 1'b0);
        a_m_ready = 1'b1;
        #1;
        check("bp_go_data",   a_m_data,  16'hBBAA);
        check("bp_go_sready", a_s_ready, 1'b0);
        tick;
        a_m_ready = 1'b0;
        #1;
        check("bp_b2_data",   a_m_data,  16'hDDCC);
        check("bp_b2_last",   a_m_last,  1'b1);
        check("bp_b2_sready_stalled", a_s_ready, 1'b0);
        a_m_ready = 1'b1;
        #1;
        check("bp_b2_sready", a_s_ready, 1'b1);
        tick;
        check("bp_idle_valid", a_m_valid, 1'b0);

        // ---------------- reset mid-word ----------------
        a_s_data = 32'hDDCC_BBAA; a_s_keep = 4'hF; a_s_last = 1'b1; a_s_valid = 1'b1;
        tick;
        a_s_valid = 1'b0; a_m_ready = 1'b0;
        #1;
        check("mid_pending_valid", a_m_valid, 1'b1);
        a_rst = 1'b1;
        tick;
        check("mid_rst_valid", a_m_valid, 1'b0);
        check("mid_rst_data",  a_m_data,  16'h0);
        check("mid_rst_last",  a_m_last,  1'b0);
        a_rst = 1'b0; a_m_ready = 1'b1;
        #1;
        check("mid_after_valid", a_m_valid, 1'b0);
        a_s_data = 32'h8765_4321; a_s_keep = 4'hF; a_s_last = 1'b0; a_s_valid = 1'b1;
        tick;
        a_s_valid = 1'b0;
        #1;
        check("mid_new_data", a_m_data, 16'h4321);
        check("mid_new_last", a_m_last, 1'b0);
        tick;
        check("mid_new_b2_data", a_m_data, 16'h8765);
        tick;
        check("mid_new_idle", a_m_valid, 1'b0);

        // ---------------- filter on: single nonzero slice ----------------
        b_s_data = 64'h4444_3333_2222_1111; b_s_keep = 8'h0C; b_s_user = 8'h0C;
        b_s_last = 1'b1; b_s_valid = 1'b1;
        tick;
        b_s_valid = 1'b0;
        #1;
        check("f1_valid", b_m_valid, 1'b1);
        check("f1_data",  b_m_data,  16'h2222);
        check("f1_keep",  b_m_keep,  2'h3);
        check("f1_user",  b_m_user,  2'h3);
        check("f1_last",  b_m_last,  1'b1);
        check("f1_sready", b_s_ready, 1'b1);
        tick;
        check("f1_idle", b_m_valid, 1'b0);

        // ---------------- filter on: zero keep, no last -> dropped ----------------
        b_s_data = 64'h5555_6666_7777_8888; b_s_keep = 8'h00; b_s_last = 1'b0; b_s_valid = 1'b1;
        #1;
        check("f0_sready", b_s_ready, 1'b1);
        tick;
        b_s_valid = 1'b0;
        #1;
        check("f0_no_beat", b_m_valid, 1'b0);
        check("f0_sready_after", b_s_ready, 1'b1);

        // ---------------- filter on: zero keep with last -> one empty beat ----------------
        b_s_data = 64'h9999_8888_7777_AAAA; b_s_keep = 8'h00; b_s_user = 8'h01;
        b_s_last = 1'b1; b_s_valid = 1'b1;
        tick;
        b_s_valid = 1'b0;
        #1;
        check("fz_valid", b_m_valid, 1'b1);
        check("fz_keep",  b_m_keep,  2'h0);
        check("fz_last",  b_m_last,  1'b1);
        check("fz_data",  b_m_data,  16'hAAAA);
        check("fz_user",  b_m_user,  2'h1);
        tick;
        check("fz_idle", b_m_valid, 1'b0);

        // ---------------- filter on: skip a zero slice between two live ones ----------------
        b_s_data = 64'h4444_3333_2222_1111; b_s_keep = 8'h33; b_s_user = 8'h00;
        b_s_last = 1'b1; b_s_valid = 1'b1;
        tick;
        b_s_valid = 1'b0;
        #1;
        check("fs_b1_data", b_m_data, 16'h1111);
        check("fs_b1_last", b_m_last, 1'b0);
        check("fs_b1_sready", b_s_ready, 1'b0);
        tick;
        check("fs_b2_data", b_m_data, 16'h3333);
        check("fs_b2_keep", b_m_keep, 2'h3);
        check("fs_b2_last", b_m_last, 1'b1);
        tick;
        check("fs_idle", b_m_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
